// File: rtl/apb_master.sv
// APB initiator: commands are queued in a small FIFO and run one at a time as
// SETUP/ACCESS transfers, each returning one response (read data or timeout).
module apb_master #(
  parameter int WORD_SIZE      = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [WORD_SIZE-1:0] cmd_addr,
  input  logic [WORD_SIZE-1:0] cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WORD_SIZE-1:0] rsp_rdata,
  output logic                 rsp_timeout,
  output logic                 busy,
  output logic [WORD_SIZE-1:0] PADDR,
  output logic [WORD_SIZE-1:0] PWDATA,
  output logic                 PWRITE,
  output logic                 PSEL,
  output logic                 PENABLE,
  input  logic [WORD_SIZE-1:0] PRDATA,
  input  logic                 PREADY
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  typedef struct packed {
    logic                 write;
    logic [WORD_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] wdata;
  } cmd_t;

  state_t               state_q, state_d;
  cmd_t                 mem_q [FIFO_DEPTH];
  cmd_t                 mem_d [FIFO_DEPTH];
  cmd_t                 head;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [TO_W-1:0]      to_cnt_inc;
  logic [WORD_SIZE-1:0] paddr_q, paddr_d;
  logic [WORD_SIZE-1:0] pwdata_q, pwdata_d;
  logic                 pwrite_q, pwrite_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [WORD_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_timeout_q, rsp_timeout_d;
  logic                 full, empty, push, pop;

  // cmd_ready comes from the registered count only; a same-cycle pop never frees a slot early
  assign full       = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty      = (count_q == '0);
  assign push       = cmd_valid & ~full;
  assign head       = mem_q[rd_ptr_q];
  assign to_cnt_inc = to_cnt_q + 1'b1;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    to_cnt_d      = to_cnt_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pwrite_d      = pwrite_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = rsp_timeout_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          paddr_d  = head.addr;
          pwdata_d = head.wdata;
          pwrite_d = head.write;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        to_cnt_d  = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // PREADY wins over an expiring counter in the same cycle
        if (PREADY) begin
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          to_cnt_d      = '0;
          state_d       = RESP;
        end else if (to_cnt_inc == TO_W'(TIMEOUT_CYCLES)) begin
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          to_cnt_d      = '0;
          state_d       = RESP;
        end else begin
          to_cnt_d = to_cnt_inc;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!empty) begin
            pop      = 1'b1;
            paddr_d  = head.addr;
            pwdata_d = head.wdata;
            pwrite_d = head.write;
            psel_d   = 1'b1;
            state_d  = SETUP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      to_cnt_q      <= '0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pwrite_q      <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      to_cnt_q      <= to_cnt_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pwrite_q      <= pwrite_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Queue payload needs no reset: the count alone decides what is valid
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign cmd_ready   = ~full;
  assign busy        = (state_q != IDLE) | ~empty;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PWRITE      = pwrite_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: table of single transfers against a wait-state
// slave model, plus queueing, timeout-follow-on and mid-transfer reset sequences.
module tb_apb_master;

  logic        clk = 1'b0;
  logic        RST;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PWRITE, PSEL, PENABLE, PREADY;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int slv_wait  = 0;
  int acc_cnt   = 0;

  always #5 clk = ~clk;

  apb_master #(.WORD_SIZE(32), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .CLK(clk), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  // Slave model: holds PREADY low for slv_wait ACCESS cycles; read data = addr ^ 0x12345670
  always @(posedge clk) begin
    if (PSEL && PENABLE) acc_cnt <= acc_cnt + 1;
    else                 acc_cnt <= 0;
  end
  assign PREADY = PSEL && PENABLE && (acc_cnt >= slv_wait);
  assign PRDATA = PWRITE ? 32'h0 : (32'h1234_5670 ^ PADDR);

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wait_n;
    int          exp_pen;
    logic [31:0] exp_rdata;
    logic        exp_to;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  task automatic run_vec(input vec_t v);
    int   n;
    int   pen;
    logic stable;
    slv_wait = v.wait_n;
    chk("idle_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 1;
    while (!PSEL && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("psel_latency", n, 2);
    chk("setup_penable", PENABLE, 0);
    chk("setup_busy", busy, 1);
    chk("setup_paddr", PADDR, v.addr);
    chk("setup_pwrite", PWRITE, v.wr);
    if (v.wr) chk("setup_pwdata", PWDATA, v.wdata);
    @(negedge clk);
    pen = 0;
    stable = 1'b1;
    while (PENABLE && pen < 100) begin
      if (!PSEL || PADDR !== v.addr || PWRITE !== v.wr || (v.wr && PWDATA !== v.wdata))
        stable = 1'b0;
      pen++;
      @(negedge clk);
    end
    chk("access_stable", stable, 1);
    chk("penable_cycles", pen, v.exp_pen);
    chk("psel_dropped", PSEL, 0);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_rdata", rsp_rdata, v.exp_rdata);
    chk("rsp_timeout", rsp_timeout, v.exp_to);
    @(negedge clk);
    chk("rsp_hold_valid", rsp_valid, 1);
    chk("rsp_hold_rdata", rsp_rdata, v.exp_rdata);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_cleared", rsp_valid, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int   k;
    int   last;
    int   hits;
    RST = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0;

    vecs[0] = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 0,  1,  32'h0,         1'b0};
    vecs[1] = '{1'b0, 32'h0000_0008, 32'h0,         3,  4,  32'h1234_5678, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_000C, 32'h0,         99, 16, 32'h0,         1'b1};
    vecs[3] = '{1'b1, 32'h0000_0020, 32'h0BAD_F00D, 1,  2,  32'h0,         1'b0};
    vecs[4] = '{1'b0, 32'h0000_0010, 32'h0,         0,  1,  32'h1234_5660, 1'b0};
    vecs[5] = '{1'b0, 32'h0000_0014, 32'h0,         15, 16, 32'h1234_5664, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_paddr", PADDR, 0);
    RST = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Timeout followed by an already-queued write
    slv_wait = 99;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_000C;
    @(negedge clk);
    cmd_write = 1'b1; cmd_addr = 32'h0000_0050; cmd_wdata = 32'hCAFE_0001;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 0; c < 40 && !rsp_valid; c++) @(negedge clk);
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_timeout", rsp_timeout, 1);
    chk("to_rdata", rsp_rdata, 0);
    slv_wait = 0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    for (int c = 0; c < 40 && !rsp_valid; c++) @(negedge clk);
    chk("next_rsp_valid", rsp_valid, 1);
    chk("next_timeout", rsp_timeout, 0);
    chk("next_paddr", PADDR, 32'h0000_0050);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Fill the FIFO with the response path stalled
    for (int i = 0; i < 5; i++) begin
      chk("fill_ready", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'(i * 4);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("full_ready", cmd_ready, 0);
    hits = 0;
    for (int c = 0; c < 12; c++) begin
      if (PSEL) hits++;
      @(negedge clk);
    end
    chk("stall_no_setup", hits, 0);
    chk("stall_rsp_valid", rsp_valid, 1);
    chk("stall_full", cmd_ready, 0);
    rsp_ready = 1'b1;
    k = 0;
    last = 0;
    for (int c = 0; c < 100 && k < 5; c++) begin
      if (rsp_valid) begin
        chk("drain_rdata", rsp_rdata, 32'h1234_5670 ^ 32'(k * 4));
        if (k > 0) chk("drain_spacing", c - last, 3);
        last = c;
        k++;
      end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    chk("drain_count", k, 5);
    chk("drain_busy", busy, 0);
    chk("drain_ready", cmd_ready, 1);

    // Reset during ACCESS of a read
    slv_wait = 5;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0030;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 0; c < 20 && !PENABLE; c++) @(negedge clk);
    chk("pre_rst_penable", PENABLE, 1);
    @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
    chk("mid_rst_psel", PSEL, 0);
    chk("mid_rst_penable", PENABLE, 0);
    chk("mid_rst_paddr", PADDR, 0);
    chk("mid_rst_pwdata", PWDATA, 0);
    chk("mid_rst_pwrite", PWRITE, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rdata", rsp_rdata, 0);
    chk("mid_rst_timeout", rsp_timeout, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_busy", busy, 0);
    hits = 0;
    for (int c = 0; c < 25; c++) begin
      if (rsp_valid || PSEL) hits++;
      @(negedge clk);
    end
    chk("post_rst_quiet", hits, 0);
    begin
      vec_t v;
      v = '{1'b1, 32'h0000_0040, 32'h5A5A_A5A5, 0, 1, 32'h0, 1'b0};
      run_vec(v);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB initiator that drives the bus side consumed by the POLI APB slave (PADDR/PWDATA/PWRITE/PSEL/PENABLE out; PRDATA/PREADY in).
- Accepts read/write commands over a valid/ready port into a small command FIFO and executes them as APB transfers.
- Returns one response per command, with a timeout flag when the slave never asserts PREADY.
- Used as the on-chip/testbench driver for POLI control-register access: CRC and NAND_NOR/XOR_BUF gate register programming and readback.

Parameters:
- WORD_SIZE, 32, address/data width (matches POLI_types_pkg WORD_SIZE).
- FIFO_DEPTH, 4, command FIFO entries; power of two, >=2.
- TIMEOUT_CYCLES, 16, max ACCESS-phase cycles waiting for PREADY before abort; >=1.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command FIFO can accept.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  WORD_SIZE  transfer address.
- cmd_wdata  in  WORD_SIZE  write data, ignored for reads.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  WORD_SIZE  read data; 0 for writes and timeouts.
- rsp_timeout  out  1  transfer aborted by timeout.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- PADDR  out  WORD_SIZE  APB address.
- PWDATA  out  WORD_SIZE  APB write data.
- PWRITE  out  1  APB direction.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PRDATA  in  WORD_SIZE  APB read data.
- PREADY  in  1  APB ready.

Behaviour:
- Reset: one clock, CLK; reset is RST, synchronous and active-high. On the reset edge all outputs go to 0 except cmd_ready, which is 1. FIFO is flushed, FSM enters IDLE and the timeout counter clears.
- Reset mid-transfer: the in-flight transfer and any pending response are discarded. No response is produced for them.
- Command FIFO:
  - Push when cmd_valid & cmd_ready.
  - cmd_ready = !full (registered count). When full, cmd_ready=0 even if a pop occurs the same cycle; there is no bypass.
  - Push and pop in the same cycle leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, SETUP, ACCESS, RESP. All APB outputs are registered.
- IDLE:
  - PSEL=0, PENABLE=0.
  - If the FIFO is non-empty: pop the head, load PADDR/PWDATA/PWRITE, go to SETUP.
- SETUP:
  - PSEL=1, PENABLE=0.
  - Unconditionally go to ACCESS next cycle.
- ACCESS:
  - PSEL=1, PENABLE=1. PADDR/PWDATA/PWRITE stay stable throughout.
  - If PREADY=1: capture rsp_rdata = PWRITE ? 0 : PRDATA, set rsp_timeout=0, go to RESP.
  - Else increment the timeout counter. If it reaches TIMEOUT_CYCLES with PREADY=0: set rsp_rdata=0, rsp_timeout=1, go to RESP. The slave sees PSEL drop.
  - PREADY sampled high on the same cycle the counter expires counts as success.
- RESP:
  - PSEL=0, PENABLE=0, rsp_valid=1. rsp_rdata/rsp_timeout held stable until rsp_ready.
  - On rsp_ready=1: clear rsp_valid. If the FIFO is non-empty, pop and go directly to SETUP; otherwise go to IDLE.
- Timing and ordering:
  - Latency: command pushed in cycle t → PSEL=1 at t+2 → PENABLE=1 at t+3 → with zero-wait PREADY, rsp_valid=1 at t+4.
  - Back-to-back throughput with rsp_ready tied high: one transfer per 3 cycles.
  - Responses return in command order; there is exactly one response per accepted command.
- Idle values: PADDR/PWDATA/PWRITE hold their last values when idle.
- busy = (state!=IDLE) | (count!=0).

Test Plan:
- Reset, then write cmd_addr=0x0000_0004, cmd_wdata=0xDEADBEEF with PREADY tied 1:
  - PSEL rises 2 cycles after acceptance, PENABLE 1 cycle later.
  - PADDR=0x4, PWDATA=0xDEADBEEF, PWRITE=1 stable over both phases.
  - Response has rsp_rdata=0, rsp_timeout=0.
- Read addr 0x8 with the slave returning PRDATA=0x1234_5678 after 3 wait cycles (PREADY low 3 ACCESS cycles):
  - PENABLE high for 4 cycles.
  - rsp_rdata=0x1234_5678, rsp_timeout=0.
- Read addr 0xC with PREADY held 0 (TIMEOUT_CYCLES=16):
  - PSEL/PENABLE drop after 16 ACCESS cycles.
  - rsp_timeout=1, rsp_rdata=0.
  - Next queued command still executes normally.
- Push 5 commands back-to-back with rsp_ready=0 (FIFO_DEPTH=4):
  - cmd_ready deasserts when full.
  - Only one transfer completes; rsp_valid is held and no SETUP occurs until rsp_ready.
  - Then the remaining commands drain in order with addresses 0x0,0x4,0x8,0xC,0x10.
- Assert RST during ACCESS of a read:
  - Next cycle all outputs are 0, cmd_ready=1, busy=0, and no response is emitted.
  - The following command executes from IDLE with correct timing.
- Three commands with rsp_ready tied 1 and PREADY tied 1:
  - Transfers occur every 3 cycles, SETUP following RESP directly.
  - Response order matches command order.
